// File: rtl/sort_job_sched_if.sv
// ---------------------------------------------------------------------------
// sort_job_sched_if
//   Plain valid/ready word stream used on both sides of the job scheduler.
//   master : produces valid/data, consumes ready
//   slave  : consumes valid/data, produces ready
//   A word transfers on a rising clock edge where valid & ready are both 1.
// ---------------------------------------------------------------------------
interface sort_job_sched_if #(
  parameter int DATA_W = 8
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/sort_job_sched.sv
// ---------------------------------------------------------------------------
// sort_job_sched
//   Job sequencer and sole owner of the sorter's single-port row memory.
//   A job is: load NUM_ROWS words from the input stream into memory, pulse
//   sort_start, hand the memory port to the sorter until sort_done, then
//   stream the sorted rows out, ending with a one-cycle job_done pulse.
//
// Ports
//   clk, rst         clock; asynchronous active-low reset (rst == 0 resets)
//   in_if  (slave)   upstream word stream (valid/ready/data)
//   out_if (master)  sorted word stream (valid/ready/data)
//   out_last         marks row NUM_ROWS-1 on the output stream
//   busy             a job is in progress (not IDLE)
//   job_done         registered pulse, the cycle after the final output word
//   sort_*           sorter control and its view of the memory port
//   mem_*            memory port: combinational read, write at clk edge
// ---------------------------------------------------------------------------
module sort_job_sched #(
  parameter int NUM_ROWS = 16,
  parameter int ADDR_W   = $clog2(NUM_ROWS),
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  sort_job_sched_if.slave   in_if,
  sort_job_sched_if.master  out_if,
  output logic              out_last,
  output logic              busy,
  output logic              job_done,
  output logic              sort_start,
  input  logic              sort_done,
  input  logic [ADDR_W-1:0] sort_rd_addr,
  output logic [DATA_W-1:0] sort_rd_data,
  input  logic              sort_wr_en,
  input  logic [ADDR_W-1:0] sort_wr_addr,
  input  logic [DATA_W-1:0] sort_wr_data,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data
);

  typedef enum logic [2:0] {IDLE, LOAD, KICK, SORT, UNLOAD} state_t;

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_ROWS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] row_cnt_q, row_cnt_d;
  logic              job_done_q, job_done_d;

  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      row_cnt_q  <= '0;
      job_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      job_done_q <= job_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    job_done_d  = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_data    = mem_rd_data;
    out_last    = 1'b0;
    sort_start  = 1'b0;
    mem_rd_addr = row_cnt_q;
    mem_wr_en   = 1'b0;
    mem_wr_addr = row_cnt_q;
    mem_wr_data = in_if.data;

    unique case (state_q)
      IDLE, LOAD: begin
        in_ready = 1'b1;
        if (in_if.valid) begin
          mem_wr_en = 1'b1;
          // Explicit wrap so non-power-of-2 row counts work.
          if (row_cnt_q == LAST_ROW) begin
            row_cnt_d = '0;
            state_d   = KICK;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
            state_d   = LOAD;
          end
        end
      end
      KICK: begin
        sort_start = 1'b1;
        state_d    = SORT;
      end
      SORT: begin
        // Sorter owns the memory port; its signals are isolated elsewhere.
        mem_rd_addr = sort_rd_addr;
        mem_wr_en   = sort_wr_en;
        mem_wr_addr = sort_wr_addr;
        mem_wr_data = sort_wr_data;
        if (sort_done) begin
          row_cnt_d = '0;
          state_d   = UNLOAD;
        end
      end
      UNLOAD: begin
        out_valid = 1'b1;
        out_last  = (row_cnt_q == LAST_ROW);
        if (out_if.ready) begin
          if (row_cnt_q == LAST_ROW) begin
            row_cnt_d  = '0;
            state_d    = IDLE;
            job_done_d = 1'b1;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_if.ready  = in_ready;
  assign out_if.valid = out_valid;
  assign out_if.data  = out_data;
  assign sort_rd_data = mem_rd_data;
  assign busy         = (state_q != IDLE);
  assign job_done     = job_done_q;

endmodule

// File: tb/tb_sort_job_sched.sv
`timescale 1ns/1ps
module tb_sort_job_sched;

  typedef logic [7:0] row_t [4];

  logic       clk;
  logic       rst;
  logic       out_last, busy, job_done, sort_start;
  logic       sort_done;
  logic [1:0] sort_rd_addr;
  logic [7:0] sort_rd_data;
  logic       sort_wr_en;
  logic [1:0] sort_wr_addr;
  logic [7:0] sort_wr_data;
  logic [1:0] mem_rd_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [1:0] mem_wr_addr;
  logic [7:0] mem_wr_data;

  int tests = 0;
  int fails = 0;

  sort_job_sched_if #(.DATA_W(8)) in_if ();
  sort_job_sched_if #(.DATA_W(8)) out_if ();

  sort_job_sched #(.NUM_ROWS(4), .DATA_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_if        (in_if),
    .out_if       (out_if),
    .out_last     (out_last),
    .busy         (busy),
    .job_done     (job_done),
    .sort_start   (sort_start),
    .sort_done    (sort_done),
    .sort_rd_addr (sort_rd_addr),
    .sort_rd_data (sort_rd_data),
    .sort_wr_en   (sort_wr_en),
    .sort_wr_addr (sort_wr_addr),
    .sort_wr_data (sort_wr_data),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row memory: combinational read, write at the clock edge. Every write
  // address is logged so tests can check write count and order.
  logic [7:0] mem [4];
  logic [1:0] wr_log [1024];
  int         wr_cnt = 0;
  int         done_cnt = 0;

  assign mem_rd_data = mem[mem_rd_addr];

  always @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_wr_addr] <= mem_wr_data;
      wr_log[wr_cnt]   <= mem_wr_addr;
      wr_cnt           <= wr_cnt + 1;
    end
    if (job_done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=<100000", $time);
    $fatal(1, "watchdog");
  end

  // Load four words; optional one-cycle bubble after each word. With poke
  // set, the sorter write port is held active (addr 2, 0xFF) and a stray
  // sort_done is injected before word 2.
  task automatic load_job(input row_t vals, input bit bubbles, input bit poke, input string tag);
    if (poke) begin
      sort_wr_en = 1'b1; sort_wr_addr = 2'd2; sort_wr_data = 8'hFF;
    end
    for (int i = 0; i < 4; i++) begin
      if (poke && i == 2) begin
        in_if.valid = 1'b0; sort_done = 1'b1;
        #1;
        tests++;
        if ({mem_wr_en, busy, in_if.ready, sort_start, out_if.valid} !== 5'b01100) begin
          fails++;
          $display("FAIL %s stray_done: we/busy/rdy/start/oval=%b required=01100", tag,
                   {mem_wr_en, busy, in_if.ready, sort_start, out_if.valid});
        end
        @(posedge clk); #1;
        sort_done = 1'b0;
      end
      in_if.valid = 1'b1; in_if.data = vals[i];
      #1;
      tests++;
      if ({in_if.ready, mem_wr_en, mem_wr_addr, mem_wr_data, sort_start} !== {1'b1, 1'b1, 2'(i), vals[i], 1'b0}) begin
        fails++;
        $display("FAIL %s load_%0d: rdy=%b we=%b addr=%0d data=%0d start=%b required rdy=1 we=1 addr=%0d data=%0d start=0",
                 tag, i, in_if.ready, mem_wr_en, mem_wr_addr, mem_wr_data, sort_start, i, vals[i]);
      end
      $display("[TB] %s in  row %0d data %0d", tag, i, vals[i]);
      @(posedge clk); #1;
      if (bubbles && i < 3) begin
        in_if.valid = 1'b0;
        #1;
        tests++;
        if ({mem_wr_en, in_if.ready, sort_start} !== 3'b010) begin
          fails++;
          $display("FAIL %s bubble_%0d: we/rdy/start=%b required=010", tag, i, {mem_wr_en, in_if.ready, sort_start});
        end
        @(posedge clk); #1;
      end
    end
    in_if.valid = 1'b0;
  endtask

  // External sorter stand-in: reads each row through the passthrough port,
  // sorts ascending, writes the rows back, then pulses sort_done.
  task automatic sort_model();
    logic [7:0] buf_v [4];
    logic [7:0] t;
    for (int i = 0; i < 4; i++) begin
      sort_rd_addr = 2'(i);
      #1;
      buf_v[i] = sort_rd_data;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3 - i; j++)
        if (buf_v[j] > buf_v[j+1]) begin
          t = buf_v[j]; buf_v[j] = buf_v[j+1]; buf_v[j+1] = t;
        end
    for (int i = 0; i < 4; i++) begin
      sort_wr_en = 1'b1; sort_wr_addr = 2'(i); sort_wr_data = buf_v[i];
      @(posedge clk); #1;
    end
    sort_wr_en = 1'b0;
    sort_done  = 1'b1;
    @(posedge clk); #1;
    sort_done  = 1'b0;
  endtask

  // Drain four rows, optionally stalling on one row and optionally driving
  // the sorter write port throughout. Returns in the job_done cycle.
  task automatic unload_job(input row_t exp, input int stall_row, input int stall_len,
                            input bit poke, input string tag);
    if (poke) begin
      sort_wr_en = 1'b1; sort_wr_addr = 2'd2; sort_wr_data = 8'hFF;
    end
    out_if.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == stall_row) begin
        out_if.ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          #1;
          tests++;
          if ({out_if.valid, out_if.data, out_last, mem_wr_en} !== {1'b1, exp[i], 1'(i == 3), 1'b0}) begin
            fails++;
            $display("FAIL %s stall_%0d_%0d: oval=%b data=%0d last=%b we=%b required oval=1 data=%0d last=%0d we=0",
                     tag, i, s, out_if.valid, out_if.data, out_last, mem_wr_en, exp[i], (i == 3));
          end
          @(posedge clk); #1;
        end
        out_if.ready = 1'b1;
      end
      #1;
      tests++;
      if ({out_if.valid, out_if.data, out_last, mem_wr_en, in_if.ready} !== {1'b1, exp[i], 1'(i == 3), 1'b0, 1'b0}) begin
        fails++;
        $display("FAIL %s out_%0d: oval=%b data=%0d last=%b we=%b rdy=%b required oval=1 data=%0d last=%0d we=0 rdy=0",
                 tag, i, out_if.valid, out_if.data, out_last, mem_wr_en, in_if.ready, exp[i], (i == 3));
      end
      $display("[TB] %s out row %0d data %0d last %b", tag, i, out_if.data, out_last);
      @(posedge clk); #1;
    end
    sort_wr_en = 1'b0;
    tests++;
    if ({job_done, busy, in_if.ready, out_if.valid} !== 4'b1010) begin
      fails++;
      $display("FAIL %s done_pulse: done/busy/rdy/oval=%b required=1010", tag,
               {job_done, busy, in_if.ready, out_if.valid});
    end
    $display("[TB] %s job_done", tag);
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if ({in_if.ready, out_if.valid, out_last, sort_start, busy, mem_wr_en, job_done} !== 7'b1000000) begin
      fails++;
      $display("FAIL reset_outputs: rdy/oval/last/start/busy/we/done=%b required=1000000",
               {in_if.ready, out_if.valid, out_last, sort_start, busy, mem_wr_en, job_done});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({busy, in_if.ready, mem_wr_en} !== 3'b010) begin
      fails++;
      $display("FAIL reset_idle_hold: busy/rdy/we=%b required=010", {busy, in_if.ready, mem_wr_en});
    end
  endtask

  task automatic test_basic();
    row_t vals = '{8'd9, 8'd3, 8'd7, 8'd1};
    row_t exp  = '{8'd1, 8'd3, 8'd7, 8'd9};
    int   base = wr_cnt;
    int   d0   = done_cnt;
    load_job(vals, 1'b0, 1'b0, "basic");
    tests++;
    if ({sort_start, in_if.ready, busy, mem_wr_en} !== 4'b1010) begin
      fails++;
      $display("FAIL basic_kick: start/rdy/busy/we=%b required=1010", {sort_start, in_if.ready, busy, mem_wr_en});
    end
    tests++;
    if (wr_cnt - base !== 4 || wr_log[base] !== 2'd0 || wr_log[base+3] !== 2'd3) begin
      fails++;
      $display("FAIL basic_writes: count=%0d first=%0d last=%0d required count=4 first=0 last=3",
               wr_cnt - base, wr_log[base], wr_log[base+3]);
    end
    @(posedge clk); #1;
    sort_rd_addr = 2'd2;
    #1;
    tests++;
    if ({sort_start, mem_rd_addr, sort_rd_data, out_if.valid} !== {1'b0, 2'd2, 8'd7, 1'b0}) begin
      fails++;
      $display("FAIL basic_sort_port: start=%b rd_addr=%0d rd_data=%0d oval=%b required start=0 rd_addr=2 rd_data=7 oval=0",
               sort_start, mem_rd_addr, sort_rd_data, out_if.valid);
    end
    @(posedge clk); #1;
    sort_model();
    unload_job(exp, -1, 0, 1'b0, "basic");
    @(posedge clk); #1;
    tests++;
    if (job_done !== 1'b0 || done_cnt - d0 !== 1) begin
      fails++;
      $display("FAIL basic_done_once: done=%b pulses=%0d required done=0 pulses=1", job_done, done_cnt - d0);
    end
  endtask

  task automatic test_bubbles();
    row_t vals = '{8'd50, 8'd20, 8'd40, 8'd30};
    row_t exp  = '{8'd20, 8'd30, 8'd40, 8'd50};
    int   base = wr_cnt;
    load_job(vals, 1'b1, 1'b0, "bubbles");
    tests++;
    if (sort_start !== 1'b1 || wr_cnt - base !== 4) begin
      fails++;
      $display("FAIL bubbles_kick: start=%b writes=%0d required start=1 writes=4", sort_start, wr_cnt - base);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (wr_log[base+i] !== 2'(i)) begin
        fails++;
        $display("FAIL bubbles_addr_%0d: addr=%0d required=%0d", i, wr_log[base+i], i);
      end
    end
    @(posedge clk); #1;
    sort_model();
    unload_job(exp, -1, 0, 1'b0, "bubbles");
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    row_t vals = '{8'd9, 8'd3, 8'd7, 8'd1};
    row_t exp  = '{8'd1, 8'd3, 8'd7, 8'd9};
    load_job(vals, 1'b0, 1'b0, "bp");
    @(posedge clk); #1;
    sort_model();
    unload_job(exp, 2, 5, 1'b0, "bp");
    @(posedge clk); #1;
  endtask

  task automatic test_isolation();
    row_t vals = '{8'd100, 8'd0, 8'd77, 8'd5};
    row_t exp  = '{8'd0, 8'd5, 8'd77, 8'd100};
    load_job(vals, 1'b0, 1'b1, "iso");
    tests++;
    if ({sort_start, mem_wr_en} !== 2'b10) begin
      fails++;
      $display("FAIL iso_kick: start/we=%b required=10", {sort_start, mem_wr_en});
    end
    sort_wr_en = 1'b0;
    @(posedge clk); #1;
    in_if.valid = 1'b1;
    #1;
    tests++;
    if (in_if.ready !== 1'b0 || mem_wr_en !== 1'b0) begin
      fails++;
      $display("FAIL iso_in_sort: rdy=%b we=%b required rdy=0 we=0", in_if.ready, mem_wr_en);
    end
    in_if.valid = 1'b0;
    sort_model();
    unload_job(exp, -1, 0, 1'b1, "iso");
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_sort();
    row_t vals  = '{8'd6, 8'd6, 8'd2, 8'd9};
    row_t vals2 = '{8'd5, 8'd2, 8'd8, 8'd4};
    row_t exp2  = '{8'd2, 8'd4, 8'd5, 8'd8};
    int   d0;
    load_job(vals, 1'b0, 1'b0, "rst");
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b1 || sort_start !== 1'b0) begin
      fails++;
      $display("FAIL rst_in_sort: busy=%b start=%b required busy=1 start=0", busy, sort_start);
    end
    d0 = done_cnt;
    #1 rst = 1'b0;
    #1;
    tests++;
    if ({state_busy_flags()} !== 4'b0010) begin
      fails++;
      $display("FAIL rst_async: busy/oval/rdy/start=%b required=0010", state_busy_flags());
    end
    #1 rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++;
    if (done_cnt !== d0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_no_done: pulses=%0d busy=%b required pulses=0 busy=0", done_cnt - d0, busy);
    end
    load_job(vals2, 1'b0, 1'b0, "rst2");
    @(posedge clk); #1;
    sort_model();
    unload_job(exp2, -1, 0, 1'b0, "rst2");
    @(posedge clk); #1;
  endtask

  function automatic logic [3:0] state_busy_flags();
    return {busy, out_if.valid, in_if.ready, sort_start};
  endfunction

  task automatic test_back_to_back();
    row_t a  = '{8'd200, 8'd10, 8'd150, 8'd60};
    row_t ea = '{8'd10, 8'd60, 8'd150, 8'd200};
    row_t b  = '{8'd4, 8'd4, 8'd0, 8'd255};
    row_t eb = '{8'd0, 8'd4, 8'd4, 8'd255};
    int   d0 = done_cnt;
    load_job(a, 1'b0, 1'b0, "b2b_a");
    @(posedge clk); #1;
    sort_model();
    unload_job(ea, -1, 0, 1'b0, "b2b_a");
    load_job(b, 1'b0, 1'b0, "b2b_b");
    tests++;
    if (sort_start !== 1'b1) begin
      fails++;
      $display("FAIL b2b_kick: start=%b required=1", sort_start);
    end
    @(posedge clk); #1;
    sort_model();
    unload_job(eb, -1, 0, 1'b0, "b2b_b");
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++;
    if (done_cnt - d0 !== 2) begin
      fails++;
      $display("FAIL b2b_done_count: pulses=%0d required=2", done_cnt - d0);
    end
  endtask

  initial begin
    rst          = 1'b0;
    in_if.valid  = 1'b0;
    in_if.data   = 8'd0;
    out_if.ready = 1'b0;
    sort_done    = 1'b0;
    sort_rd_addr = 2'd0;
    sort_wr_en   = 1'b0;
    sort_wr_addr = 2'd0;
    sort_wr_data = 8'd0;
    test_reset();
    test_basic();
    test_bubbles();
    test_backpressure();
    test_isolation();
    test_reset_in_sort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
